// File: rtl/mano_bus_regfile.sv
// Mano-style common-bus register file: NREG registers with per-register load/inc/dec/clr strobes.
// Optional decrement support is compiled in with `define REGFILE_DEC_EN.

module mano_bus_regfile_cell #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] bus,
  input  logic             ld,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [WIDTH-1:0] q,
  output logic             wrap
);

`ifndef REGFILE_DEC_EN
  // dec is kept on the port list in every build but has no effect here.
  logic unused_dec;
  assign unused_dec = dec;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (ld) begin
        q <= bus;
      end else if (inc) begin
        q    <= q + WIDTH'(1);
        wrap <= &q;
`ifdef REGFILE_DEC_EN
      end else if (dec) begin
        q    <= q - WIDTH'(1);
        wrap <= ~|q;
`endif
      end else if (clr) begin
        q <= '0;
      end
    end
  end

endmodule

module mano_bus_regfile #(
  parameter int WIDTH = 16,
  parameter int NREG  = 7,
  parameter int SEL_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SEL_W-1:0]      bus_sel,
  input  logic [WIDTH-1:0]      mem_in,
  input  logic [NREG-1:0]       ld,
  input  logic [NREG-1:0]       inc,
  input  logic [NREG-1:0]       dec,
  input  logic [NREG-1:0]       clr,
  output logic [WIDTH-1:0]      bus,
  output logic [NREG*WIDTH-1:0] reg_q,
  output logic [NREG-1:0]       wrap
);

  generate
    if (NREG < 1 || NREG > 15 || (2**SEL_W) < NREG + 1) begin : g_bad_param
      $error("mano_bus_regfile: illegal NREG/SEL_W combination");
    end
  endgenerate

  logic [NREG-1:0][WIDTH-1:0] q;

  // Unused select codes fall through to zero so the bus is never floating.
  always_comb begin
    bus = '0;
    if (bus_sel == '0) begin
      bus = mem_in;
    end else begin
      for (int k = 1; k <= NREG; k++) begin
        if (bus_sel == SEL_W'(k)) bus = q[k-1];
      end
    end
  end

  generate
    for (genvar i = 0; i < NREG; i++) begin : g_reg
      mano_bus_regfile_cell #(.WIDTH(WIDTH)) u_cell (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus),
        .ld   (ld[i]),
        .inc  (inc[i]),
        .dec  (dec[i]),
        .clr  (clr[i]),
        .q    (q[i]),
        .wrap (wrap[i])
      );
    end
  endgenerate

  assign reg_q = q;

endmodule

// File: doc/mano_bus_regfile.md
MANO_BUS_REGFILE -- requirements
Module: mano_bus_regfile

Interface
REQ-001 Parameter WIDTH, default 16: bit width of every register and of the common bus.
REQ-002 Parameter NREG, default 7: number of registers on the bus, 1 to 15.
REQ-003 Parameter SEL_W, default 4: bus-select width; SHALL satisfy 2**SEL_W >= NREG+1.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1: reset, asynchronous and active-low.
REQ-006 bus_sel  input  SEL_W: bus source; 0 selects mem_in, k (1..NREG) selects register k-1.
REQ-007 mem_in  input  WIDTH: memory read data driven onto the bus when bus_sel=0.
REQ-008 ld  input  NREG: per-register load-from-bus strobe.
REQ-009 inc  input  NREG: per-register increment strobe.
REQ-010 dec  input  NREG: per-register decrement strobe; used only when REGFILE_DEC_EN is defined.
REQ-011 clr  input  NREG: per-register clear strobe.
REQ-012 bus  output  WIDTH: current common-bus value.
REQ-013 reg_q  output  NREG*WIDTH: all register contents; register i occupies bits [i*WIDTH +: WIDTH].
REQ-014 wrap  output  NREG: registered one-cycle pulse per register on increment (or decrement) wrap-around.

Function
REQ-015 bus SHALL be purely combinational from bus_sel, mem_in and current register contents, with zero-cycle latency.
REQ-016 bus_sel values above NREG SHALL drive bus to all zeros; bus is never high-impedance.
REQ-017 Per register, one action per edge; priority ld > inc > dec > clr; no strobe: hold.
REQ-018 ld: register takes the bus value sampled at that edge, which is the pre-edge value of any selected source register.
REQ-019 Self-load (ld[i] with bus_sel=i+1) SHALL leave register i unchanged.
REQ-020 Swap: ld[i] and ld[j] in the same cycle capture the same bus value; register-to-register swap is not supported in one cycle.
REQ-021 inc: register += 1 modulo 2**WIDTH; an all-ones value becomes 0 and sets wrap[i]=1 for the next cycle only.
REQ-022 dec (macro defined): register -= 1 modulo 2**WIDTH; a value of 0 becomes all-ones and sets wrap[i]=1 for the next cycle only.
REQ-023 clr: register becomes 0; wrap[i]=0 next cycle.
REQ-024 wrap[i] SHALL be 0 in every cycle not immediately following a wrapping inc or dec of register i.
REQ-025 Strobes on different registers are independent, and all NREG registers may update on the same edge.
REQ-026 reg_q SHALL reflect the register state directly, with no added pipeline stage.

Reset
REQ-027 rst_n low SHALL immediately force every register to 0 and wrap to 0, regardless of clk.
REQ-028 While rst_n is low, all strobes are ignored; bus still follows mem_in when bus_sel=0 and reads 0 for register sources.
REQ-029 The first edge with rst_n high applies strobes normally; reset asserted mid-operation discards any pending wrap pulse.

Configuration
REQ-030 Macro REGFILE_DEC_EN defined: dec is active at the priority given in REQ-017.
REQ-031 Macro REGFILE_DEC_EN undefined: dec is ignored, no decrement logic is synthesised, and the dec port remains present.

Verification
REQ-032 Reset: rst_n=0 mid-run with registers nonzero -> reg_q=0 and wrap=0 with no clk edge; bus_sel=0, mem_in=16'h1234 -> bus=16'h1234.
REQ-033 Transfer: mem_in=16'h00AB, bus_sel=0, ld[0]=1; next cycle bus_sel=1, ld[3]=1 -> reg0=reg3=16'h00AB.
REQ-034 Priority: ld[2]=inc[2]=clr[2]=1 with bus=16'h0005 -> reg2=16'h0005; next cycle inc[2]=clr[2]=1 -> reg2=16'h0006.
REQ-035 Wrap: reg1=16'hFFFF, inc[1]=1 -> reg1=16'h0000 and wrap[1]=1 for exactly one cycle; wrap[0]=0.
REQ-036 Decrement: with REGFILE_DEC_EN, reg4=0 and dec[4]=1 -> reg4=16'hFFFF and wrap[4] pulses; without the macro, reg4 holds 0.
REQ-037 Out-of-range select: bus_sel=15 with NREG=7, ld[5]=1 -> bus=0 and reg5=0.
